key_debounce: RTL

- Conditions one raw mechanical push-button input into a clean, glitch-free level.
- Also emits single-cycle press/release strobes.
- Sits directly upstream of the toggle flip-flop stage: the press strobe (or clean level) drives that stage's toggle input, so one physical press yields exactly one toggle.
- Contains a two-flop synchronizer, a stability counter and a four-state FSM.

---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 42 ++++
 rtl/key_debounce.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
//
// Purpose:
//   Holds the shared constants and helpers for the push-button debouncer.
//   It contains the default qualification time and the counter width helper.
//   Other button/switch conditioning blocks on the board can reuse it.
//
// Contents:
//   KD_DEFAULT_STABLE_CYCLES - default qualification time (20 ms @ 100 MHz)
//   kd_cnt_width()           - width needed to hold 0..n inclusive
// -----------------------------------------------------------------------------
package key_debounce_pkg;

    // 20 ms at a 100 MHz system clock.
    localparam int unsigned KD_DEFAULT_STABLE_CYCLES = 2_000_000;

    // Bits needed to represent every value from 0 up to and including n.
    function automatic int unsigned kd_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage : key_debounce_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   A 1-bit two-flop synchronizer for slow asynchronous levels such as buttons
//   and switches. The output q follows d two rising edges later. The first
//   flop is allowed to go metastable, and the second flop gives it a full
//   cycle to resolve.
//
// Ports:
//   clk - system clock, all state updates on its rising edge
//   rst - synchronous, active-high reset; both flops clear to 0
//   d   - asynchronous input level
//   q   - synchronized level (2-edge latency)
// -----------------------------------------------------------------------------
module sync_2ff
    import key_debounce_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking (<=) so that both flops sample
    // their pre-edge values; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Purpose:
//   Conditions one raw mechanical push-button into a clean debounced level,
//   plus single-cycle press/release strobes. The press strobe feeds the
//   downstream toggle stage, so one physical press produces exactly one
//   toggle.
//
//   The input first passes through a two-flop synchronizer. A four-state FSM
//   then requires the synchronized input to differ from the current clean
//   level for STABLE_CYCLES consecutive edges before the level flips. Any
//   shorter excursion returns the FSM to its settled state and discards the
//   count. The latency from key_in to key_level is STABLE_CYCLES + 2 edges.
//
// Parameters:
//   STABLE_CYCLES - qualification time in clock cycles (legal range >= 2)
//
// Ports:
//   clk         - system clock, all state updates on its rising edge
//   rst         - synchronous, active-high reset
//   key_in      - raw asynchronous button level, 1 = pressed
//   key_level   - debounced level, 1 = pressed
//   key_press   - one-cycle strobe on a debounced 0->1 change
//   key_release - one-cycle strobe on a debounced 1->0 change
// -----------------------------------------------------------------------------
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = KD_DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    // Derived width. This is deliberately not a parameter, so it cannot be
    // overridden out of step with STABLE_CYCLES.
    localparam int unsigned CNT_W = kd_cnt_width(STABLE_CYCLES);

    // The count value that completes qualification. The edge that sees the
    // new level with the counter at this value is the STABLE_CYCLES-th such
    // edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,   // settled released, key_level = 0
        S_WAIT_HIGH = 2'd1,   // qualifying a press, key_level = 0
        S_HIGH      = 2'd2,   // settled pressed, key_level = 1
        S_WAIT_LOW  = 2'd3    // qualifying a release, key_level = 1
    } state_t;

    logic             w_sync;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_level_next;
    logic             w_press_next;
    logic             w_release_next;

    // ------------------------------------------------------------------
    // Synchronizer: only its output is used below.
    // ------------------------------------------------------------------
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (w_sync)
    );

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal is given a default before the case statement, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = '0;        // the counter rests at 0 in settled states
        w_level_next   = r_level;
        w_press_next   = 1'b0;      // the strobes are high only on the completing edge
        w_release_next = 1'b0;

        case (r_state)
            S_LOW: begin
                // This edge is the first one showing the new level, so the
                // count starts at 1.
                if (w_sync) begin
                    w_state_next = S_WAIT_HIGH;
                    w_cnt_next   = CNT_W'(1);
                end
            end

            S_WAIT_HIGH: begin
                if (!w_sync) begin
                    w_state_next = S_LOW;            // bounce rejected
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_HIGH;
                    w_level_next = 1'b1;
                    w_press_next = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end

            S_HIGH: begin
                if (!w_sync) begin
                    w_state_next = S_WAIT_LOW;
                    w_cnt_next   = CNT_W'(1);
                end
            end

            S_WAIT_LOW: begin
                if (w_sync) begin
                    w_state_next = S_HIGH;           // bounce rejected
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = S_LOW;
                    w_level_next   = 1'b0;
                    w_release_next = 1'b1;
                end else begin
                    w_cnt_next     = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                // Recovery from a corrupted state register.
                w_state_next = S_LOW;
                w_level_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= w_level_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule : key_debounce
